// File: rtl/segre_hf_controller.sv
`default_nettype none
// ============================================================================
// Module      : segre_hf_controller
// Description : History-file controller. Tracks in-order allocation, out-of-order
//               completion, in-order retire and newest-to-oldest rollback.
// Revision    : 1.0
// ============================================================================
module segre_hf_controller #(
    parameter int HF_SIZE   = 8,
    parameter int HF_PTR    = 3,
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_i,
    input  logic                 alloc_rf_we_i,
    input  logic [REG_SIZE-1:0]  alloc_rd_i,
    input  logic [WORD_SIZE-1:0] alloc_old_data_i,
    input  logic                 alloc_store_i,
    input  logic [WORD_SIZE-1:0] alloc_addr_i,
    output logic [HF_PTR-1:0]    alloc_id_o,
    output logic                 full_o,
    output logic                 stall_o,
    input  logic                 cmp_ex_i,
    input  logic                 cmp_mem_i,
    input  logic                 cmp_rvm_i,
    input  logic [HF_PTR-1:0]    cmp_ex_id_i,
    input  logic [HF_PTR-1:0]    cmp_mem_id_i,
    input  logic [HF_PTR-1:0]    cmp_rvm_id_i,
    input  logic                 cmp_ex_exc_i,
    input  logic                 cmp_mem_exc_i,
    input  logic                 cmp_rvm_exc_i,
    output logic                 commit_o,
    output logic [HF_PTR-1:0]    commit_id_o,
    output logic                 rf_rst_we_o,
    output logic [REG_SIZE-1:0]  rf_rst_addr_o,
    output logic [WORD_SIZE-1:0] rf_rst_data_o,
    output logic                 mem_rst_we_o,
    output logic [WORD_SIZE-1:0] mem_rst_addr_o,
    output logic [WORD_SIZE-1:0] mem_rst_data_o,
    output logic                 flush_o,
    output logic                 exc_o,
    output logic [HF_PTR-1:0]    exc_id_o
);

    localparam logic [HF_PTR-1:0] PTR_ONE  = HF_PTR'(1);
    localparam logic [HF_PTR:0]   CNT_ONE  = (HF_PTR+1)'(1);
    localparam logic [HF_PTR:0]   CNT_FULL = (HF_PTR+1)'(HF_SIZE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROLLBACK = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [HF_PTR-1:0] head, tail, rb, exc_id;
    logic [HF_PTR:0]   count;

    logic [HF_SIZE-1:0] valid, done, exc;
    logic [HF_SIZE-1:0] valid_n, done_n, exc_n;

    logic [HF_SIZE-1:0]   ent_rf_we, ent_store;
    logic [REG_SIZE-1:0]  ent_rd   [HF_SIZE];
    logic [WORD_SIZE-1:0] ent_addr [HF_SIZE];
    logic [WORD_SIZE-1:0] ent_old  [HF_SIZE];

    logic [2:0]        cmp_v, cmp_e;
    logic [HF_PTR-1:0] cmp_id [3];

    logic alloc_ok, retire, exc_take, rb_last;

    assign cmp_v     = {cmp_ex_i, cmp_mem_i, cmp_rvm_i};
    assign cmp_e     = {cmp_ex_exc_i, cmp_mem_exc_i, cmp_rvm_exc_i};
    assign cmp_id[2] = cmp_ex_id_i;
    assign cmp_id[1] = cmp_mem_id_i;
    assign cmp_id[0] = cmp_rvm_id_i;

    assign full_o     = (count == CNT_FULL);
    assign stall_o    = full_o | (state != IDLE);
    assign alloc_ok   = alloc_i & ~stall_o;
    assign alloc_id_o = head;

    assign retire   = (state == IDLE) & valid[tail] & done[tail] & ~exc[tail];
    assign exc_take = (state == IDLE) & valid[tail] & done[tail] &  exc[tail];
    assign rb_last  = (rb == exc_id);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (exc_take) state_next = ROLLBACK;
            ROLLBACK: if (rb_last)  state_next = FLUSH;
            FLUSH:    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Completions merge first so that several ports hitting one id OR their
    // exception flags; allocation of the same index then overrides them.
    always_comb begin
        valid_n = valid;
        done_n  = done;
        exc_n   = exc;
        if (state == IDLE) begin
            for (int p = 0; p < 3; p++) begin
                if (cmp_v[p] && valid[cmp_id[p]]) begin
                    done_n[cmp_id[p]] = 1'b1;
                    exc_n[cmp_id[p]]  = exc_n[cmp_id[p]] | cmp_e[p];
                end
            end
            if (retire) begin
                valid_n[tail] = 1'b0;
            end
            if (alloc_ok) begin
                valid_n[head] = 1'b1;
                done_n[head]  = 1'b0;
                exc_n[head]   = 1'b0;
            end
        end else if (state == ROLLBACK) begin
            valid_n[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_ok) begin
            ent_rf_we[head] <= alloc_rf_we_i;
            ent_store[head] <= alloc_store_i;
            ent_rd[head]    <= alloc_rd_i;
            ent_addr[head]  <= alloc_addr_i;
            ent_old[head]   <= alloc_old_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            rb             <= '0;
            exc_id         <= '0;
            valid          <= '0;
            done           <= '0;
            exc            <= '0;
            commit_o       <= 1'b0;
            commit_id_o    <= '0;
            rf_rst_we_o    <= 1'b0;
            rf_rst_addr_o  <= '0;
            rf_rst_data_o  <= '0;
            mem_rst_we_o   <= 1'b0;
            mem_rst_addr_o <= '0;
            mem_rst_data_o <= '0;
            flush_o        <= 1'b0;
            exc_o          <= 1'b0;
            exc_id_o       <= '0;
        end else begin
            valid <= valid_n;
            done  <= done_n;
            exc   <= exc_n;

            if (alloc_ok) head <= head + PTR_ONE;
            if (retire)   tail <= tail + PTR_ONE;

            if (alloc_ok && !retire) begin
                count <= count + CNT_ONE;
            end else if (!alloc_ok && retire) begin
                count <= count - CNT_ONE;
            end

            commit_o    <= retire;
            commit_id_o <= retire ? tail : '0;

            if (exc_take) begin
                rb     <= head - PTR_ONE;
                exc_id <= tail;
            end

            if (state == ROLLBACK) begin
                rf_rst_we_o    <= ent_rf_we[rb];
                rf_rst_addr_o  <= ent_rd[rb];
                rf_rst_data_o  <= ent_old[rb];
                mem_rst_we_o   <= ent_store[rb];
                mem_rst_addr_o <= ent_addr[rb];
                mem_rst_data_o <= ent_old[rb];
                if (!rb_last) rb <= rb - PTR_ONE;
            end else begin
                rf_rst_we_o    <= 1'b0;
                rf_rst_addr_o  <= '0;
                rf_rst_data_o  <= '0;
                mem_rst_we_o   <= 1'b0;
                mem_rst_addr_o <= '0;
                mem_rst_data_o <= '0;
            end

            if (state == FLUSH) begin
                flush_o  <= 1'b1;
                exc_o    <= 1'b1;
                exc_id_o <= exc_id;
                head     <= exc_id + PTR_ONE;
                tail     <= exc_id + PTR_ONE;
                count    <= '0;
            end else begin
                flush_o  <= 1'b0;
                exc_o    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segre_hf_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_segre_hf_controller
// Description : Vector-table and directed-sequence bench for segre_hf_controller.
// Revision    : 1.0
// ============================================================================
module tb_segre_hf_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alloc_i, alloc_rf_we_i, alloc_store_i;
    logic [4:0]  alloc_rd_i;
    logic [31:0] alloc_old_data_i, alloc_addr_i;
    logic [2:0]  alloc_id_o;
    logic        full_o, stall_o;
    logic        cmp_ex_i, cmp_mem_i, cmp_rvm_i;
    logic [2:0]  cmp_ex_id_i, cmp_mem_id_i, cmp_rvm_id_i;
    logic        cmp_ex_exc_i, cmp_mem_exc_i, cmp_rvm_exc_i;
    logic        commit_o;
    logic [2:0]  commit_id_o;
    logic        rf_rst_we_o;
    logic [4:0]  rf_rst_addr_o;
    logic [31:0] rf_rst_data_o;
    logic        mem_rst_we_o;
    logic [31:0] mem_rst_addr_o, mem_rst_data_o;
    logic        flush_o, exc_o;
    logic [2:0]  exc_id_o;

    int n_tests = 0;
    int n_fail  = 0;

    segre_hf_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc_i(alloc_i), .alloc_rf_we_i(alloc_rf_we_i), .alloc_rd_i(alloc_rd_i),
        .alloc_old_data_i(alloc_old_data_i), .alloc_store_i(alloc_store_i),
        .alloc_addr_i(alloc_addr_i), .alloc_id_o(alloc_id_o),
        .full_o(full_o), .stall_o(stall_o),
        .cmp_ex_i(cmp_ex_i), .cmp_mem_i(cmp_mem_i), .cmp_rvm_i(cmp_rvm_i),
        .cmp_ex_id_i(cmp_ex_id_i), .cmp_mem_id_i(cmp_mem_id_i), .cmp_rvm_id_i(cmp_rvm_id_i),
        .cmp_ex_exc_i(cmp_ex_exc_i), .cmp_mem_exc_i(cmp_mem_exc_i), .cmp_rvm_exc_i(cmp_rvm_exc_i),
        .commit_o(commit_o), .commit_id_o(commit_id_o),
        .rf_rst_we_o(rf_rst_we_o), .rf_rst_addr_o(rf_rst_addr_o), .rf_rst_data_o(rf_rst_data_o),
        .mem_rst_we_o(mem_rst_we_o), .mem_rst_addr_o(mem_rst_addr_o),
        .mem_rst_data_o(mem_rst_data_o),
        .flush_o(flush_o), .exc_o(exc_o), .exc_id_o(exc_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic       alloc;
        logic [2:0] cv;      // {ex, mem, rvm}
        logic [2:0] id_ex, id_mem, id_rvm;
        logic [2:0] ce;
        logic       e_commit;
        logic [2:0] e_cid;
        logic       e_full, e_stall;
        logic [2:0] e_aid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [2:0] cv,
                                input logic [2:0] ie, input logic [2:0] im, input logic [2:0] ir,
                                input logic [2:0] ce, input logic c, input logic [2:0] cid,
                                input logic f, input logic s, input logic [2:0] aid);
        vec_t v;
        v.rst = r; v.alloc = a; v.cv = cv; v.id_ex = ie; v.id_mem = im; v.id_rvm = ir;
        v.ce = ce; v.e_commit = c; v.e_cid = cid; v.e_full = f; v.e_stall = s; v.e_aid = aid;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_cmp();
        cmp_ex_i = 0; cmp_mem_i = 0; cmp_rvm_i = 0;
        cmp_ex_id_i = 0; cmp_mem_id_i = 0; cmp_rvm_id_i = 0;
        cmp_ex_exc_i = 0; cmp_mem_exc_i = 0; cmp_rvm_exc_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1; tick(); rst_i = 0;
    endtask

    task automatic do_alloc(input logic we, input logic [4:0] rd, input logic [31:0] old,
                            input logic st, input logic [31:0] addr, input logic [2:0] exp_id);
        chk("alloc_id", alloc_id_o, exp_id);
        alloc_i = 1; alloc_rf_we_i = we; alloc_rd_i = rd; alloc_old_data_i = old;
        alloc_store_i = st; alloc_addr_i = addr;
        tick();
        alloc_i = 0;
    endtask

    task automatic chk_restore(input string nm, input logic rwe, input logic [4:0] ra,
                               input logic [31:0] rd, input logic mwe, input logic [31:0] ma,
                               input logic [31:0] md);
        chk({nm, ".rf_we"}, rf_rst_we_o, rwe);
        chk({nm, ".mem_we"}, mem_rst_we_o, mwe);
        if (rwe) begin
            chk({nm, ".rf_addr"}, rf_rst_addr_o, ra);
            chk({nm, ".rf_data"}, rf_rst_data_o, rd);
        end
        if (mwe) begin
            chk({nm, ".mem_addr"}, mem_rst_addr_o, ma);
            chk({nm, ".mem_data"}, mem_rst_data_o, md);
        end
        chk({nm, ".flush"}, flush_o, 1'b0);
    endtask

    initial begin
        rst_i = 1; alloc_i = 0; alloc_rf_we_i = 0; alloc_rd_i = 0;
        alloc_old_data_i = 0; alloc_store_i = 0; alloc_addr_i = 0;
        clear_cmp();
        tick(); tick();
        rst_i = 0;

        chk("rst.commit", commit_o, 0);
        chk("rst.full", full_o, 0);
        chk("rst.stall", stall_o, 0);
        chk("rst.alloc_id", alloc_id_o, 0);
        chk("rst.flush", flush_o, 0);
        chk("rst.rf_we", rf_rst_we_o, 0);
        chk("rst.mem_we", mem_rst_we_o, 0);

        // In-order retire of out-of-order completions, then fill/full corner cases
        tbl.push_back(mk(1,0,3'b000,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 0,0,0,0,2));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 0,0,0,0,3));
        tbl.push_back(mk(0,0,3'b101,2,0,2,0, 0,0,0,0,3));
        tbl.push_back(mk(0,0,3'b100,0,0,0,0, 0,0,0,0,3));
        tbl.push_back(mk(0,0,3'b010,0,1,0,0, 1,0,0,0,3));
        tbl.push_back(mk(0,0,3'b000,0,0,0,0, 1,1,0,0,3));
        tbl.push_back(mk(0,0,3'b000,0,0,0,0, 1,2,0,0,3));
        tbl.push_back(mk(0,0,3'b000,0,0,0,0, 0,0,0,0,3));
        tbl.push_back(mk(1,0,3'b000,0,0,0,0, 0,0,0,0,0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0,1,3'b000,0,0,0,0, 0,0,(k==8),(k==8),3'(k % 8)));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,1,3'b001,0,0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1,3'b000,0,0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,3'b000,0,0,0,0, 0,0,1,1,1));

        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; alloc_i = tbl[i].alloc;
            {cmp_ex_i, cmp_mem_i, cmp_rvm_i} = tbl[i].cv;
            {cmp_ex_exc_i, cmp_mem_exc_i, cmp_rvm_exc_i} = tbl[i].ce;
            cmp_ex_id_i = tbl[i].id_ex; cmp_mem_id_i = tbl[i].id_mem; cmp_rvm_id_i = tbl[i].id_rvm;
            tick();
            chk($sformatf("v%0d.commit", i), commit_o, tbl[i].e_commit);
            chk($sformatf("v%0d.commit_id", i), commit_id_o, tbl[i].e_cid);
            chk($sformatf("v%0d.full", i), full_o, tbl[i].e_full);
            chk($sformatf("v%0d.stall", i), stall_o, tbl[i].e_stall);
            chk($sformatf("v%0d.alloc_id", i), alloc_id_o, tbl[i].e_aid);
        end
        rst_i = 0; alloc_i = 0; clear_cmp();

        // Rollback of entries 3..1 after entry 1 excepts
        do_reset();
        do_alloc(1, 5'd1, 32'h99, 0, 32'h0, 3'd0);
        do_alloc(1, 5'd5, 32'h11, 0, 32'h0, 3'd1);
        do_alloc(0, 5'd0, 32'hAB, 1, 32'h100, 3'd2);
        do_alloc(1, 5'd6, 32'h22, 0, 32'h0, 3'd3);
        cmp_ex_i = 1; cmp_ex_id_i = 0; cmp_mem_i = 1; cmp_mem_id_i = 1; cmp_mem_exc_i = 1;
        tick(); clear_cmp();
        chk("rb1.commit_early", commit_o, 0);
        tick();
        chk("rb1.commit0", commit_o, 1);
        chk("rb1.commit0_id", commit_id_o, 0);
        tick();
        chk("rb1.stall", stall_o, 1);
        chk("rb1.no_restore_yet", rf_rst_we_o, 0);
        tick(); chk_restore("rb1.e3", 1, 5'd6, 32'h22, 0, 0, 0);
        tick(); chk_restore("rb1.e2", 0, 0, 0, 1, 32'h100, 32'hAB);
        tick(); chk_restore("rb1.e1", 1, 5'd5, 32'h11, 0, 0, 0);
        tick();
        chk("rb1.flush", flush_o, 1);
        chk("rb1.exc", exc_o, 1);
        chk("rb1.exc_id", exc_id_o, 1);
        chk("rb1.rf_we_after", rf_rst_we_o, 0);
        chk("rb1.stall_after", stall_o, 0);
        tick();
        chk("rb1.flush_pulse", flush_o, 0);
        do_alloc(1, 5'd7, 32'h5, 0, 32'h0, 3'd2);
        cmp_rvm_i = 1; cmp_rvm_id_i = 2;
        tick(); clear_cmp();
        tick();
        chk("rb1.tail_commit", commit_o, 1);
        chk("rb1.tail_commit_id", commit_id_o, 2);

        // Wrapped rollback: tail = 6, head = 1
        do_reset();
        for (int k = 0; k < 6; k++) begin
            do_alloc(0, 5'(k), 32'(k), 0, 32'h0, 3'(k));
            cmp_ex_i = 1; cmp_ex_id_i = 3'(k);
            tick(); clear_cmp();
        end
        tick(); tick();
        do_alloc(1, 5'd10, 32'h60, 0, 32'h0, 3'd6);
        do_alloc(0, 5'd0, 32'h70, 1, 32'h200, 3'd7);
        do_alloc(1, 5'd12, 32'h80, 0, 32'h0, 3'd0);
        chk("wrap.head", alloc_id_o, 1);
        cmp_ex_i = 1; cmp_ex_id_i = 6; cmp_rvm_i = 1; cmp_rvm_id_i = 6; cmp_rvm_exc_i = 1;
        tick(); clear_cmp();
        tick();
        chk("wrap.stall", stall_o, 1);
        chk("wrap.no_commit", commit_o, 0);
        alloc_i = 1;
        tick(); chk_restore("wrap.e0", 1, 5'd12, 32'h80, 0, 0, 0);
        tick(); chk_restore("wrap.e7", 0, 0, 0, 1, 32'h200, 32'h70);
        tick(); chk_restore("wrap.e6", 1, 5'd10, 32'h60, 0, 0, 0);
        tick();
        alloc_i = 0;
        chk("wrap.flush", flush_o, 1);
        chk("wrap.exc", exc_o, 1);
        chk("wrap.exc_id", exc_id_o, 6);
        chk("wrap.head_after", alloc_id_o, 7);

        // Reset while rolling back
        do_reset();
        for (int k = 0; k < 3; k++)
            do_alloc(1, 5'(20 + k), 32'(32'h300 + k), 0, 32'h0, 3'(k));
        cmp_ex_i = 1; cmp_ex_id_i = 0; cmp_ex_exc_i = 1;
        tick(); clear_cmp();
        tick();
        tick(); chk_restore("rstrb.e2", 1, 5'd22, 32'h302, 0, 0, 0);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("rstrb.rf_we", rf_rst_we_o, 0);
        chk("rstrb.rf_data", rf_rst_data_o, 0);
        chk("rstrb.mem_we", mem_rst_we_o, 0);
        chk("rstrb.flush", flush_o, 0);
        chk("rstrb.exc", exc_o, 0);
        chk("rstrb.stall", stall_o, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rstrb.quiet%0d", k), {rf_rst_we_o, mem_rst_we_o, flush_o}, 3'b000);
        end
        do_alloc(1, 5'd1, 32'h1, 0, 32'h0, 3'd0);
        chk("rstrb.next_id", alloc_id_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/segre_hf_controller.md
Name: segre_hf_controller

Overview:
- History-file controller for the in-order-issue / out-of-order-completion pipelines (EX, MEM, RVM5).
- Allocates one entry per register-writing or store instruction leaving ID and records the old register/memory value.
- Tracks completion from the three pipelines and retires entries in program order.
- On an excepting instruction, walks the buffer newest-to-oldest, emits restore writes, then flushes.

Parameters:
HF_SIZE, 8, number of history-file entries
HF_PTR, 3, entry index width, log2(HF_SIZE)
WORD_SIZE, 32, data/address width
REG_SIZE, 5, register index width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
alloc_i  in  1  ID requests new entry this cycle
alloc_rf_we_i  in  1  entry writes a register
alloc_rd_i  in  REG_SIZE  destination register
alloc_old_data_i  in  WORD_SIZE  old rd value, or old memory word for stores
alloc_store_i  in  1  entry is a store
alloc_addr_i  in  WORD_SIZE  store address
alloc_id_o  out  HF_PTR  id assigned to an accepted allocation (= head pointer)
full_o  out  1  no free entry (combinational from count)
stall_o  out  1  full_o or state != IDLE
cmp_ex_i, cmp_mem_i, cmp_rvm_i  in  1 each  completion valid per pipeline
cmp_ex_id_i, cmp_mem_id_i, cmp_rvm_id_i  in  HF_PTR each  completing entry id
cmp_ex_exc_i, cmp_mem_exc_i, cmp_rvm_exc_i  in  1 each  completion raised an exception
commit_o  out  1  registered, one entry retired
commit_id_o  out  HF_PTR  retired entry id
rf_rst_we_o  out  1  register restore write
rf_rst_addr_o  out  REG_SIZE  restore register
rf_rst_data_o  out  WORD_SIZE  restore value
mem_rst_we_o  out  1  memory restore write
mem_rst_addr_o  out  WORD_SIZE  restore address
mem_rst_data_o  out  WORD_SIZE  restore data
flush_o  out  1  one-cycle pipeline flush pulse
exc_o  out  1  pulse with flush_o; exception taken
exc_id_o  out  HF_PTR  id of the excepting entry

Behaviour:
- Reset: all outputs 0, state IDLE, head = tail = count = 0, all entry valid/done/exc bits cleared. Reset during ROLLBACK or FLUSH abandons the walk; no restore writes are issued.
- Entry state: valid, done, exc, rf_we, store, rd, addr, old_data.
- Allocation: accepted iff alloc_i && !stall_o.
  - Writes entry[head] (valid = 1, done = 0, exc = 0). head += 1 mod HF_SIZE.
  - alloc_id_o = head before the increment.
  - Rejected allocation: no state change. The requester must hold the request.
- Completion:
  - Each cmp_*_i with a valid target entry sets done; exc |= cmp_*_exc_i.
  - Multiple ports hitting the same id in one cycle: done = 1, exc = OR of all exc inputs.
  - Completion to an invalid entry is ignored.
  - A completion and an allocation to the same index in one cycle cannot be legal; allocation wins.
- Retire (IDLE only, at most one per cycle): entry[tail] valid && done && !exc.
  - Clear valid, tail += 1 mod HF_SIZE.
  - Next cycle: commit_o = 1, commit_id_o = old tail.
- Count: +1 on accepted allocation, -1 on retire; both in one cycle leaves it unchanged.
  - full_o = (count == HF_SIZE).
  - Full with a same-cycle retire: the allocation is still rejected (full_o uses the registered count).
- Exception detect: in IDLE, entry[tail] valid && done && exc.
  - Go to ROLLBACK with rb = head-1 mod HF_SIZE. Latch exc_id = tail. No commit.
- ROLLBACK, once per cycle for entry rb:
  - Next cycle: rf_rst_we_o = rf_we, rf_rst_addr_o = rd, rf_rst_data_o = old_data; mem_rst_we_o = store, mem_rst_addr_o = addr, mem_rst_data_o = old_data.
  - Clear valid[rb].
  - If rb == exc_id go to FLUSH, else rb -= 1 mod HF_SIZE.
  - The excepting entry itself is restored. Allocation and completions are ignored.
- FLUSH, one cycle:
  - Next cycle: flush_o = 1, exc_o = 1, exc_id_o = latched id.
  - head = tail = exc_id + 1 mod HF_SIZE, count = 0. Return to IDLE.
- Latency: N live entries from the excepting one to the newest take N ROLLBACK cycles plus 1 FLUSH cycle. The restore/flush pulse lags state by one cycle.
- Wrap-around: all pointer arithmetic is modulo HF_SIZE. Rollback across index 0 must work.

Test Plan:
- Reset, then alloc 3 entries (ids 0,1,2), complete in order 2,0,1 → commit_o pulses for ids 0,1,2 in consecutive cycles after id1 completes; no commit before id0 is done.
- Alloc 8 entries with no completion → full_o = 1 and stall_o = 1; 9th alloc_i rejected, head stays at 0; complete id0 → next retire drops full_o.
- Full buffer, retire of id0 and alloc_i in the same cycle → alloc rejected; accepted the following cycle with id 0.
- Entries 0..3 (1 and 3 rf_we to x5/x6 with old 0x11/0x22; 2 a store at 0x100, old 0xAB); entry 1 completes with exc → restores in order: entry3 rf x6 = 0x22, entry2 mem 0x100 = 0xAB, entry1 rf x5 = 0x11; then flush_o/exc_o with exc_id_o = 1; head = tail = 2.
- Rollback with head = 1, tail = 6 (wrapped) → restores entries 0,7,6 in order, then flush.
- rst_i asserted mid-ROLLBACK → no further restore pulses; all outputs 0 next cycle; the next allocation gets id 0.
